vertex_fetch_seq: RTL and testbench

//  Upstream sequencer for matrix_mul: walks a vertex buffer in BRAM, issuing one 4x1 multiply per

---
 rtl/vertex_fetch_seq_pkg.sv | 17 +
 rtl/vfs_fifo.sv | 48 ++++
 rtl/vertex_fetch_seq.sv | 127 ++++++++++++
 tb/tb_vertex_fetch_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vertex_fetch_seq_pkg.sv
// Shared constants and FSM encoding for the vertex fetch sequencer and its FIFO.
package vertex_fetch_seq_pkg;
  localparam int VERTEX_W      = 128;
  localparam int WORD_W        = 32;
  localparam int VERTEX_STRIDE = 16;

  localparam logic MATRIX_MODELVIEW  = 1'b0;
  localparam logic MATRIX_PROJECTION = 1'b1;
  localparam logic MUL_TYPE_4X1      = 1'b0;
  localparam logic MUL_TYPE_4X4      = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } vfs_state_e;
endpackage

// File: rtl/vfs_fifo.sv
// First-word-fall-through FIFO; head is read straight from the register array.
module vfs_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      // Push into a full FIFO is only legal alongside a pop, which frees the head slot.
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/vertex_fetch_seq.sv
// Issues one 4x1 multiply per vertex to matrix_mul under credit control and
// captures each result into an output FIFO after a fixed latency.
module vertex_fetch_seq
  import vertex_fetch_seq_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int ISSUE_GAP   = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int STRIDE      = VERTEX_STRIDE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WORD_W-1:0]   base_addr,
  input  logic [15:0]         vertex_count,
  input  logic                matrix_mode_in,
  output logic                busy,
  output logic                done,
  output logic                mul_en,
  output logic                mul_type,
  output logic                mul_matrix_mode,
  output logic [WORD_W-1:0]   mul_addr,
  input  logic [VERTEX_W-1:0] vertex_in,
  output logic [VERTEX_W-1:0] vout_data,
  output logic                vout_valid,
  input  logic                vout_ready
);
  localparam int GW  = $clog2(ISSUE_GAP + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  vfs_state_e         state_q;
  logic               busy_q, done_q, mul_en_q, mode_q;
  logic [WORD_W-1:0]  mul_addr_q, next_addr_q;
  logic [15:0]        count_q, issued_q;
  logic [GW-1:0]      gap_q;
  logic [MUL_LATENCY-1:0] lat_q;
  logic [7:0]         inflight;
  logic [FCW-1:0]     fifo_cnt;
  logic               credit_ok, can_issue, push;

  // In-flight includes the pulse currently on mul_en, not yet in the delay line.
  always_comb begin
    inflight = {7'd0, mul_en_q};
    for (int i = 0; i < MUL_LATENCY; i++) inflight = inflight + {7'd0, lat_q[i]};
  end

  assign credit_ok = (32'(fifo_cnt) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign can_issue = (issued_q != count_q) && (gap_q == '0) && credit_ok;
  assign push      = lat_q[MUL_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_en_q    <= 1'b0;
      mode_q      <= MATRIX_MODELVIEW;
      mul_addr_q  <= '0;
      next_addr_q <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      gap_q       <= '0;
      lat_q       <= '0;
    end else begin
      mul_en_q <= 1'b0;
      done_q   <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 1'b1;
      lat_q[0] <= mul_en_q;
      for (int i = 1; i < MUL_LATENCY; i++) lat_q[i] <= lat_q[i-1];

      case (state_q)
        ST_IDLE: begin
          // A start coinciding with the done pulse belongs to the finished batch.
          if (start && !done_q) begin
            busy_q      <= 1'b1;
            count_q     <= vertex_count;
            issued_q    <= '0;
            next_addr_q <= base_addr;
            mode_q      <= matrix_mode_in;
            gap_q       <= '0;
            state_q     <= (vertex_count == 16'd0) ? ST_WAIT : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issued_q == count_q) begin
            state_q <= ST_WAIT;
          end else if (can_issue) begin
            mul_en_q    <= 1'b1;
            mul_addr_q  <= next_addr_q;
            next_addr_q <= next_addr_q + WORD_W'(STRIDE);
            issued_q    <= issued_q + 16'd1;
            gap_q       <= GW'(ISSUE_GAP - 1);
          end
        end
        ST_WAIT: begin
          if (inflight == 8'd0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  vfs_fifo #(
    .WIDTH (VERTEX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (vertex_in),
    .pop_i   (vout_ready),
    .head_o  (vout_data),
    .valid_o (vout_valid),
    .count_o (fifo_cnt)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign mul_en          = mul_en_q;
  assign mul_type        = MUL_TYPE_4X1;
  assign mul_matrix_mode = mode_q;
  assign mul_addr        = mul_addr_q;
endmodule

// File: tb/tb_vertex_fetch_seq.sv
// Directed bench for vertex_fetch_seq with a behavioural matrix_mul stand-in.
module tb_vertex_fetch_seq;
  localparam int MUL_LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [15:0]  vertex_count = '0;
  logic         matrix_mode_in = 1'b0;
  logic         busy, done, mul_en, mul_type, mul_matrix_mode;
  logic [31:0]  mul_addr;
  logic [127:0] vertex_in;
  logic [127:0] vout_data;
  logic         vout_valid;
  logic         vout_ready = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vertex_fetch_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .vertex_count    (vertex_count),
    .matrix_mode_in  (matrix_mode_in),
    .busy            (busy),
    .done            (done),
    .mul_en          (mul_en),
    .mul_type        (mul_type),
    .mul_matrix_mode (mul_matrix_mode),
    .mul_addr        (mul_addr),
    .vertex_in       (vertex_in),
    .vout_data       (vout_data),
    .vout_valid      (vout_valid),
    .vout_ready      (vout_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] vx(input logic [31:0] a, input logic m);
    return {a, ~a, 32'hC0DE0000 | {31'd0, m}, a + 32'd1};
  endfunction

  // matrix_mul stand-in: fixed-latency result derived from address and mode
  logic [127:0] mm_pipe [MUL_LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) mm_pipe[i] <= '0;
    end else begin
      mm_pipe[0] <= mul_en ? vx(mul_addr, mul_matrix_mode) : '0;
      for (int i = 1; i < MUL_LAT; i++) mm_pipe[i] <= mm_pipe[i-1];
    end
  end
  assign vertex_in = mm_pipe[MUL_LAT-1];

  logic [31:0]  iss_addr [512];
  int           iss_cyc  [512];
  logic [127:0] pop_data [512];
  int           vr_cyc   [512];
  int iss_n = 0, pop_n = 0, done_n = 0, done_cyc = 0, vr_n = 0;
  logic vv_prev = 1'b0;

  always @(negedge clk) begin
    if (mul_en) begin
      iss_addr[iss_n] <= mul_addr;
      iss_cyc[iss_n]  <= cyc;
      iss_n           <= iss_n + 1;
    end
    if (vout_valid && vout_ready) begin
      pop_data[pop_n] <= vout_data;
      pop_n           <= pop_n + 1;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (vout_valid && !vv_prev) begin
      vr_cyc[vr_n] <= cyc;
      vr_n         <= vr_n + 1;
    end
    vv_prev <= vout_valid;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]       base;
    logic [15:0]       cnt;
    logic              mode;
    logic              restart;
    logic [0:3][31:0]  exp_addr;
  } vec_t;

  vec_t vecs [5];

  task automatic wait_done(input int d0, input int limit, input string nm);
    int waited = 0;
    while (done_n == d0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= limit) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic run_batch(input vec_t v);
    int i0, p0, d0, r0, sc, waited;
    logic busy_bad;
    i0 = iss_n; p0 = pop_n; d0 = done_n; r0 = vr_n;
    vout_ready = 1'b1;
    @(negedge clk);
    base_addr = v.base; vertex_count = v.cnt; matrix_mode_in = v.mode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sc = cyc;
    waited = 0;
    busy_bad = 1'b0;
    while (done_n == d0 && waited < 400) begin
      if (!busy && !done) busy_bad = 1'b1;
      if (v.restart && waited == 2) begin
        start = 1'b1; base_addr = 32'h100; vertex_count = 16'd9; matrix_mode_in = ~v.mode;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      waited++;
    end
    start = 1'b0;
    if (waited >= 400) chk("batch_timeout", 1, 0);
    repeat (6) @(negedge clk);
    chk("n_issue", 128'(iss_n - i0), 128'(v.cnt));
    chk("n_pop", 128'(pop_n - p0), 128'(v.cnt));
    chk("n_done", 128'(done_n - d0), 128'd1);
    chk("busy_held", 128'(busy_bad), 128'd0);
    if (v.cnt == 16'd0) begin
      chk("done_lat_zero", 128'(done_cyc - sc), 128'd1);
      chk("no_valid_zero", 128'(vr_n - r0), 128'd0);
    end else begin
      chk("first_valid_lat", 128'(vr_cyc[r0] - sc), 128'(MUL_LAT + 2));
      chk("first_issue_lat", 128'(iss_cyc[i0] - sc), 128'd1);
    end
    for (int i = 0; i < int'(v.cnt) && i < 4; i++) begin
      chk($sformatf("addr%0d", i), 128'(iss_addr[i0+i]), 128'(v.exp_addr[i]));
      chk($sformatf("data%0d", i), pop_data[p0+i], vx(v.exp_addr[i], v.mode));
      if (i > 0) chk($sformatf("gap%0d", i), 128'(iss_cyc[i0+i] - iss_cyc[i0+i-1]), 128'd5);
    end
  endtask

  initial begin
    int i0, p0, d0, waited;

    vecs[0] = '{base: 32'h0000_0000, cnt: 16'd4, mode: 1'b0, restart: 1'b0,
                exp_addr: '{32'h00, 32'h10, 32'h20, 32'h30}};
    vecs[1] = '{base: 32'hFFFF_FFE0, cnt: 16'd3, mode: 1'b1, restart: 1'b0,
                exp_addr: '{32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0}};
    vecs[2] = '{base: 32'h0000_0000, cnt: 16'd0, mode: 1'b0, restart: 1'b0,
                exp_addr: '{32'h0, 32'h0, 32'h0, 32'h0}};
    vecs[3] = '{base: 32'h0000_0040, cnt: 16'd3, mode: 1'b0, restart: 1'b1,
                exp_addr: '{32'h40, 32'h50, 32'h60, 32'h0}};
    vecs[4] = '{base: 32'h1234_5670, cnt: 16'd1, mode: 1'b1, restart: 1'b0,
                exp_addr: '{32'h1234_5670, 32'h0, 32'h0, 32'h0}};

    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_done", 128'(done), 0);
    chk("rst_mul_en", 128'(mul_en), 0);
    chk("rst_mul_type", 128'(mul_type), 0);
    chk("rst_mode", 128'(mul_matrix_mode), 0);
    chk("rst_addr", 128'(mul_addr), 0);
    chk("rst_vvalid", 128'(vout_valid), 0);
    chk("rst_vdata", vout_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 5; k++) run_batch(vecs[k]);

    // Consumer stalled: credit limits issue to FIFO depth, then drains on ready
    i0 = iss_n; p0 = pop_n; d0 = done_n;
    vout_ready = 1'b0;
    @(negedge clk);
    base_addr = 32'h1000; vertex_count = 16'd8; matrix_mode_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    chk("stall_issues", 128'(iss_n - i0), 128'd4);
    chk("stall_vvalid", 128'(vout_valid), 1);
    chk("stall_busy", 128'(busy), 1);
    chk("stall_pops", 128'(pop_n - p0), 0);
    chk("stall_head", vout_data, vx(32'h1000, 1'b0));
    vout_ready = 1'b1;
    wait_done(d0, 400, "stall");
    repeat (6) @(negedge clk);
    chk("stall_total_issue", 128'(iss_n - i0), 128'd8);
    chk("stall_total_pop", 128'(pop_n - p0), 128'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stall_addr%0d", i), 128'(iss_addr[i0+i]), 128'(32'h1000 + 32'(16 * i)));
      chk($sformatf("stall_data%0d", i), pop_data[p0+i], vx(32'h1000 + 32'(16 * i), 1'b0));
    end

    // Asynchronous reset mid-batch
    i0 = iss_n;
    @(negedge clk);
    base_addr = 32'h2000; vertex_count = 16'd4; matrix_mode_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (iss_n - i0 < 2 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) chk("reset_wait_timeout", 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 0);
    chk("arst_done", 128'(done), 0);
    chk("arst_mul_en", 128'(mul_en), 0);
    chk("arst_mode", 128'(mul_matrix_mode), 0);
    chk("arst_addr", 128'(mul_addr), 0);
    chk("arst_vvalid", 128'(vout_valid), 0);
    chk("arst_vdata", vout_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_issues", 128'(iss_n - i0), 128'd2);
    chk("post_rst_busy", 128'(busy), 0);
    chk("post_rst_vvalid", 128'(vout_valid), 0);
    run_batch('{base: 32'h3000, cnt: 16'd2, mode: 1'b1, restart: 1'b0,
                exp_addr: '{32'h3000, 32'h3010, 32'h0, 32'h0}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
